// File: rtl/round_timer.sv
// Round countdown: IDLE/RUN/DONE FSM, seconds prescaler, binary and BCD seconds display.
// All outputs registered; start/abort take effect on the sampling edge, abort always wins.
module round_timer #(
  parameter int CLK_HZ    = 40000000,
  parameter int ROUND_SEC = 60
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       sec_tick,
  output logic [6:0] time_left,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [6:0]    TIME_INIT = 7'(ROUND_SEC);
  localparam logic [3:0]    TENS_INIT = 4'(ROUND_SEC / 10);
  localparam logic [3:0]    ONES_INIT = 4'(ROUND_SEC % 10);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [6:0]    time_q;
  logic [3:0]    tens_q;
  logic [3:0]    ones_q;
  logic          running_q;
  logic          expired_q;
  logic          done_q;
  logic          tick_q;

  logic wrap_d;
  assign wrap_d = (presc_q == PRESC_MAX);

  always_ff @(posedge pclk) begin
    expired_q <= 1'b0;
    tick_q    <= 1'b0;
    if (!rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      time_q    <= TIME_INIT;
      tens_q    <= TENS_INIT;
      ones_q    <= ONES_INIT;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!abort && start) begin
            state_q   <= RUN;
            presc_q   <= '0;
            time_q    <= TIME_INIT;
            tens_q    <= TENS_INIT;
            ones_q    <= ONES_INIT;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            time_q    <= TIME_INIT;
            tens_q    <= TENS_INIT;
            ones_q    <= ONES_INIT;
            running_q <= 1'b0;
          end else if (wrap_d) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
            time_q  <= time_q - 7'd1;
            // BCD borrow keeps tens*10+ones locked to time_left
            if (ones_q == 4'd0) begin
              ones_q <= 4'd9;
              tens_q <= tens_q - 4'd1;
            end else begin
              ones_q <= ones_q - 4'd1;
            end
            if (time_q == 7'd1) begin
              state_q   <= DONE;
              expired_q <= 1'b1;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        DONE: begin
          if (abort) begin
            state_q <= IDLE;
            presc_q <= '0;
            time_q  <= TIME_INIT;
            tens_q  <= TENS_INIT;
            ones_q  <= ONES_INIT;
            done_q  <= 1'b0;
          end else if (start) begin
            state_q   <= RUN;
            presc_q   <= '0;
            time_q    <= TIME_INIT;
            tens_q    <= TENS_INIT;
            ones_q    <= ONES_INIT;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          presc_q   <= '0;
          time_q    <= TIME_INIT;
          tens_q    <= TENS_INIT;
          ones_q    <= ONES_INIT;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign running   = running_q;
  assign expired   = expired_q;
  assign done      = done_q;
  assign sec_tick  = tick_q;
  assign time_left = time_q;
  assign tens      = tens_q;
  assign ones      = ones_q;

endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer with CLK_HZ=10, ROUND_SEC=12.
module tb_round_timer;

  localparam int CLK_HZ    = 10;
  localparam int ROUND_SEC = 12;

  logic       pclk  = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       running;
  logic       expired;
  logic       done;
  logic       sec_tick;
  logic [6:0] time_left;
  logic [3:0] tens;
  logic [3:0] ones;

  int n_tests = 0;
  int n_fail  = 0;

  round_timer #(.CLK_HZ(CLK_HZ), .ROUND_SEC(ROUND_SEC)) dut (
    .pclk(pclk), .rst(rst), .start(start), .abort(abort),
    .running(running), .expired(expired), .done(done), .sec_tick(sec_tick),
    .time_left(time_left), .tens(tens), .ones(ones)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    check({tag, "_time"},    int'(time_left), 12);
    check({tag, "_tens"},    int'(tens), 1);
    check({tag, "_ones"},    int'(ones), 2);
    check({tag, "_running"}, int'(running), 0);
    check({tag, "_done"},    int'(done), 0);
    check({tag, "_expired"}, int'(expired), 0);
    check({tag, "_tick"},    int'(sec_tick), 0);
  endtask

  task automatic begin_round(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_running"}, int'(running), 1);
    check({tag, "_time"},    int'(time_left), 12);
    check({tag, "_done"},    int'(done), 0);
    check({tag, "_tick"},    int'(sec_tick), 0);
  endtask

  // Edges 1..last after the start edge; a stray start at edge 35 must be ignored.
  task automatic countdown(input int last);
    int exp_t;
    for (int k = 1; k <= last; k++) begin
      start = (k == 35);
      tick();
      start = 1'b0;
      exp_t = 12 - k / 10;
      check("cd_time",    int'(time_left), exp_t);
      check("cd_tens",    int'(tens), exp_t / 10);
      check("cd_ones",    int'(ones), exp_t % 10);
      check("cd_tick",    int'(sec_tick), int'(k % 10 == 0));
      check("cd_expired", int'(expired), int'(k == 120));
      check("cd_running", int'(running), int'(k < 120));
      check("cd_done",    int'(done), int'(k == 120));
    end
  endtask

  initial begin
    rst = 1'b0;
    tick();
    tick();
    idle_chk("reset");
    rst = 1'b1;
    tick();
    idle_chk("idle");

    // full countdown, then DONE holds
    begin_round("start0");
    countdown(30);
    check("step10to9_tens", int'(tens), 0);
    check("step10to9_ones", int'(ones), 9);
    for (int k = 31; k <= 120; k++) begin
      tick();
    end
    check("e120_time",    int'(time_left), 0);
    check("e120_expired", int'(expired), 1);
    check("e120_running", int'(running), 0);
    check("e120_done",    int'(done), 1);
    tick();
    check("e121_expired", int'(expired), 0);
    check("e121_done",    int'(done), 1);
    check("e121_time",    int'(time_left), 0);
    tick();
    tick();
    check("done_hold_time", int'(time_left), 0);
    check("done_hold_tens", int'(tens), 0);
    check("done_hold_ones", int'(ones), 0);
    check("done_hold_done", int'(done), 1);

    // restart from DONE, abort at cycle 55
    begin_round("restart");
    countdown(54);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    idle_chk("abort55");
    tick();
    idle_chk("abort55_hold");

    // simultaneous start and abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    idle_chk("start_abort");
    tick();
    idle_chk("start_abort_hold");

    // abort on the final wrap edge
    begin_round("start_fw");
    countdown(119);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    idle_chk("abort_wrap");
    tick();
    idle_chk("abort_wrap_hold");

    // reset mid-countdown at cycle 73, start ignored while in reset
    begin_round("start_rst");
    countdown(72);
    rst = 1'b0;
    tick();
    idle_chk("rst73");
    start = 1'b1;
    tick();
    start = 1'b0;
    idle_chk("rst_start_ignored");
    rst = 1'b1;
    repeat (5) tick();
    idle_chk("post_rst");
    begin_round("start80");
    countdown(20);

    // abort from DONE
    countdown_done: begin
      for (int k = 21; k <= 120; k++) begin
        tick();
      end
    end
    check("done2_done", int'(done), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    idle_chk("done_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/round_timer.md
ROUND_TIMER -- requirements
Module: round_timer

Interface
REQ-001 Parameter CLK_HZ, default 40000000, pclk cycles per game second.
REQ-002 Parameter ROUND_SEC, default 60, round length in seconds; legal range 1..99.
REQ-003 pclk  input  1  pixel clock; the block's only clock.
REQ-004 rst  input  1  reset; synchronous and active-low, sampled on rising pclk.
REQ-005 start  input  1  one-cycle pulse from the game FSM; starts or restarts a round.
REQ-006 abort  input  1  one-cycle pulse (mouse stop click); cancels the round.
REQ-007 running  output  1  level; high while the countdown is active.
REQ-008 expired  output  1  one-cycle pulse when the countdown reaches zero.
REQ-009 done  output  1  level; high from expiry until the next start or abort.
REQ-010 sec_tick  output  1  one-cycle pulse on every seconds decrement.
REQ-011 time_left  output  7  remaining seconds, binary.
REQ-012 tens, ones  output  4 each  remaining seconds as BCD digits for the character ROM.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, and every output SHALL be registered.
REQ-014 IDLE: time_left=ROUND_SEC, BCD matches it, running=0, done=0; start -> RUN.
REQ-015 On entering RUN, time_left SHALL load ROUND_SEC and the prescaler SHALL clear to 0.
- running rises on the edge that samples start (latency 1 cycle).
REQ-016 In RUN the prescaler SHALL count 0..CLK_HZ-1 and wrap.
- On the wrap edge: time_left decrements by 1, tens/ones decrement in BCD (ones 0 -> 9 with a tens borrow), sec_tick pulses.
- The first decrement lands exactly CLK_HZ cycles after running rises; later ones land every CLK_HZ cycles.
REQ-017 The wrap edge that takes time_left from 1 to 0 SHALL do all of the following on the same edge:
- assert expired for one cycle and sec_tick
- clear running, set done, enter DONE.
REQ-018 DONE: time_left=0, tens=0, ones=0, done=1, prescaler held.
- start -> RUN with a reload per REQ-015.
- abort -> IDLE.
REQ-019 abort in RUN SHALL go to IDLE on the next edge with time_left reloaded to ROUND_SEC; no expired or sec_tick pulse.
REQ-020 Simultaneous start and abort SHALL be resolved as abort: abort wins in every state.
REQ-021 abort on the same cycle as the final wrap SHALL win: IDLE, no expired, no sec_tick.
REQ-022 start while in RUN SHALL be ignored; the countdown continues undisturbed.
REQ-023 The prescaler width SHALL be $clog2(CLK_HZ); no other counter may overflow for legal parameters.
REQ-024 tens*10+ones SHALL equal time_left on every cycle.

Reset
REQ-025 rst=0 at a rising edge SHALL force IDLE in any state, including mid-countdown, and set:
- running=0, expired=0, done=0, sec_tick=0
- time_left=ROUND_SEC, tens/ones = BCD of ROUND_SEC
- prescaler=0.
REQ-026 While rst=0, start and abort SHALL be ignored; the first start is accepted on the first edge with rst=1.

Verification (CLK_HZ=10, ROUND_SEC=12)
REQ-027 Reset then idle -> time_left=12, tens=1, ones=2, running=0, done=0.
REQ-028 start pulse at cycle 0 -> running=1 after edge 0.
- time_left=11 (tens=1, ones=1) with sec_tick after edge 10.
- 10, 9, 8 ... each 10 cycles after the previous step.
- 10 -> 9 step: tens=0, ones=9.
REQ-029 Full countdown -> at edge 120, time_left=0 and expired=1 for exactly 1 cycle, running=0, done stays 1.
- A later start reloads time_left=12 and running=1.
REQ-030 abort at cycle 55 -> IDLE after edge 55 with time_left=12; no expired pulse.
REQ-031 start and abort in the same cycle while IDLE -> remains IDLE.
- abort on the final wrap edge -> IDLE, expired never asserts.
REQ-032 rst=0 at cycle 73 mid-countdown -> all outputs at reset values after edge 73.
- start at cycle 80 -> normal countdown from 12.
